// File: rtl/bounce_check_scheduler.sv
// bounce_check_scheduler
//   Shares one wall-collision checker (sprite box vs tile map) among N_SPR
//   sprites. A frame_start pulse snapshots every sprite's box, direction and
//   bouncing state. The enabled sprites then go to the checker one at a time.
//   The returned bounce flags are held in a shadow store. All results are
//   committed to the motion logic together, in a single cycle.
//
// Parameters
//   N_SPR    number of sprites sharing the checker (1..8)
//   CHK_LAT  checker latency in cycles from chk_* to chk_bnce (0..15)
//
// Ports
//   Clk, Reset_n     clock (rising edge), asynchronous active-low reset
//   frame_start      1-cycle frame start pulse
//   spr_en           per-sprite enable; disabled sprites are skipped and get 0
//   spr_xpos/ypos    20-bit position of sprite i at [20i+:20]
//   spr_W/H          10-bit size of sprite i at [10i+:10]
//   spr_dir/bcing    {U,D,L,R} direction / bouncing flags of sprite i
//   chk_*            selected sprite, driven to the checker (registered)
//   chk_bnce         {L,D,U,R} bounce request from the checker
//   bnce_out         committed bounce nibble per sprite
//   coll_out         committed OR of each sprite's bounce nibble
//   busy             high from frame accept through the commit cycle
//   done             pulse in the commit cycle
//   overrun          pulse the cycle after a frame_start arriving while busy
module bounce_check_scheduler #(
  parameter int N_SPR   = 4,
  parameter int CHK_LAT = 0
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_start,
  input  logic [N_SPR-1:0]     spr_en,
  input  logic [20*N_SPR-1:0]  spr_xpos,
  input  logic [20*N_SPR-1:0]  spr_ypos,
  input  logic [10*N_SPR-1:0]  spr_W,
  input  logic [10*N_SPR-1:0]  spr_H,
  input  logic [4*N_SPR-1:0]   spr_dir,
  input  logic [4*N_SPR-1:0]   spr_bcing,
  output logic [19:0]          chk_xpos,
  output logic [19:0]          chk_ypos,
  output logic [9:0]           chk_W,
  output logic [9:0]           chk_H,
  output logic [3:0]           chk_dir,
  output logic [3:0]           chk_bcing,
  input  logic [3:0]           chk_bnce,
  output logic [4*N_SPR-1:0]   bnce_out,
  output logic [N_SPR-1:0]     coll_out,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int IDX_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [3:0]           lat_cnt;

  logic [N_SPR-1:0]     snap_en;
  logic [20*N_SPR-1:0]  snap_xpos, snap_ypos;
  logic [10*N_SPR-1:0]  snap_w, snap_h;
  logic [4*N_SPR-1:0]   snap_dir, snap_bcing;
  logic [4*N_SPR-1:0]   shadow;

  logic                 accept, slot_end;
  logic                 first_vld, next_vld;
  logic [IDX_W-1:0]     first_idx, next_idx;

  logic                 chk_load, chk_clear;
  logic [19:0]          ld_xpos, ld_ypos;
  logic [9:0]           ld_w, ld_h;
  logic [3:0]           ld_dir, ld_bcing;

  // Lowest enabled index at or above start, with a found flag in the MSB.
  // The loop runs downward so that the lowest match is the last one written.
  function automatic logic [IDX_W:0] find_enabled(input logic [N_SPR-1:0] en,
                                                  input int start);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (en[i] && (i >= start)) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  // The first sprite is chosen from the live enables, because the snapshot
  // is loaded in the same edge. Later sprites come from the snapshot.
  assign {first_vld, first_idx} = find_enabled(spr_en, 0);
  assign {next_vld, next_idx}   = find_enabled(snap_en, int'(idx) + 1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    slot_end  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          accept    = 1'b1;
          state_nxt = first_vld ? SCAN : COMMIT;
        end
      end
      SCAN: begin
        if (lat_cnt == 4'(CHK_LAT)) begin
          slot_end = 1'b1;
          if (!next_vld) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Source of the next checker operands: live inputs on accept, snapshot otherwise
  always_comb begin
    chk_load  = (accept && first_vld) || (slot_end && next_vld);
    chk_clear = slot_end && !next_vld;
    if (accept) begin
      ld_xpos  = spr_xpos[20*int'(first_idx) +: 20];
      ld_ypos  = spr_ypos[20*int'(first_idx) +: 20];
      ld_w     = spr_W[10*int'(first_idx) +: 10];
      ld_h     = spr_H[10*int'(first_idx) +: 10];
      ld_dir   = spr_dir[4*int'(first_idx) +: 4];
      ld_bcing = spr_bcing[4*int'(first_idx) +: 4];
    end else begin
      ld_xpos  = snap_xpos[20*int'(next_idx) +: 20];
      ld_ypos  = snap_ypos[20*int'(next_idx) +: 20];
      ld_w     = snap_w[10*int'(next_idx) +: 10];
      ld_h     = snap_h[10*int'(next_idx) +: 10];
      ld_dir   = snap_dir[4*int'(next_idx) +: 4];
      ld_bcing = snap_bcing[4*int'(next_idx) +: 4];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx        <= '0;
      lat_cnt    <= '0;
      snap_en    <= '0;
      snap_xpos  <= '0;
      snap_ypos  <= '0;
      snap_w     <= '0;
      snap_h     <= '0;
      snap_dir   <= '0;
      snap_bcing <= '0;
      shadow     <= '0;
      chk_xpos   <= '0;
      chk_ypos   <= '0;
      chk_W      <= '0;
      chk_H      <= '0;
      chk_dir    <= '0;
      chk_bcing  <= '0;
      bnce_out   <= '0;
      coll_out   <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= frame_start && busy;

      if (accept) begin
        snap_en    <= spr_en;
        snap_xpos  <= spr_xpos;
        snap_ypos  <= spr_ypos;
        snap_w     <= spr_W;
        snap_h     <= spr_H;
        snap_dir   <= spr_dir;
        snap_bcing <= spr_bcing;
        shadow     <= '0;
        lat_cnt    <= '0;
        idx        <= first_idx;
      end

      if (state == SCAN) begin
        if (slot_end) begin
          shadow[4*int'(idx) +: 4] <= chk_bnce;
          lat_cnt                  <= '0;
          if (next_vld) idx <= next_idx;
        end else begin
          lat_cnt <= lat_cnt + 4'd1;
        end
      end

      // Checker operands stay constant for the whole slot and return to 0 once the scan ends
      if (chk_load) begin
        chk_xpos  <= ld_xpos;
        chk_ypos  <= ld_ypos;
        chk_W     <= ld_w;
        chk_H     <= ld_h;
        chk_dir   <= ld_dir;
        chk_bcing <= ld_bcing;
      end else if (chk_clear) begin
        chk_xpos  <= '0;
        chk_ypos  <= '0;
        chk_W     <= '0;
        chk_H     <= '0;
        chk_dir   <= '0;
        chk_bcing <= '0;
      end

      if (state == COMMIT) begin
        bnce_out <= shadow;
        for (int i = 0; i < N_SPR; i++) coll_out[i] <= |shadow[4*i +: 4];
      end
    end
  end

endmodule

// File: tb/tb_bounce_check_scheduler.sv
// tb_bounce_check_scheduler
//   Two instances share the same sprite inputs and frame_start. One has a
//   combinational checker (CHK_LAT=0). The other has a checker with a 2-cycle
//   pipeline (CHK_LAT=2). The bench starts with a table of hand-derived frames
//   and then runs hand-written reset and overrun sequences. It finishes with
//   randomized frames whose inputs are scrambled during the scan. A frame-level
//   model checks every frame.
module tb_bounce_check_scheduler;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         frame_start;
  logic [3:0]   spr_en;
  logic [79:0]  spr_xpos, spr_ypos;
  logic [39:0]  spr_W, spr_H;
  logic [15:0]  spr_dir, spr_bcing;

  logic [19:0]  chk_xpos0, chk_ypos0, chk_xpos2, chk_ypos2;
  logic [9:0]   chk_W0, chk_H0, chk_W2, chk_H2;
  logic [3:0]   chk_dir0, chk_bcing0, chk_dir2, chk_bcing2;
  logic [3:0]   chk_bnce0, chk_bnce2;
  logic [15:0]  bnce_out0, bnce_out2;
  logic [3:0]   coll_out0, coll_out2;
  logic         busy0, busy2, done0, done2, overrun0, overrun2;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  // Stand-in wall checker: an arbitrary but deterministic function of the box
  function automatic logic [3:0] chk_fn(input logic [19:0] x, input logic [19:0] y,
                                        input logic [9:0] w, input logic [9:0] h,
                                        input logic [3:0] d, input logic [3:0] b);
    return x[3:0] ^ y[3:0] ^ y[7:4] ^ w[3:0] ^ h[3:0] ^ d ^ b;
  endfunction

  assign chk_bnce0 = chk_fn(chk_xpos0, chk_ypos0, chk_W0, chk_H0, chk_dir0, chk_bcing0);

  logic [3:0] pipe_a, pipe_b;
  always_ff @(posedge Clk) begin
    pipe_a <= chk_fn(chk_xpos2, chk_ypos2, chk_W2, chk_H2, chk_dir2, chk_bcing2);
    pipe_b <= pipe_a;
  end
  assign chk_bnce2 = pipe_b;

  logic [67:0] chk_v [2];
  logic [15:0] bnce_v [2];
  logic [3:0]  coll_v [2];
  logic [1:0]  done_v, busy_v, ovr_v;
  assign chk_v[0]  = {chk_xpos0, chk_ypos0, chk_W0, chk_H0, chk_dir0, chk_bcing0};
  assign chk_v[1]  = {chk_xpos2, chk_ypos2, chk_W2, chk_H2, chk_dir2, chk_bcing2};
  assign bnce_v[0] = bnce_out0;
  assign bnce_v[1] = bnce_out2;
  assign coll_v[0] = coll_out0;
  assign coll_v[1] = coll_out2;
  assign done_v    = {done2, done0};
  assign busy_v    = {busy2, busy0};
  assign ovr_v     = {overrun2, overrun0};

  bounce_check_scheduler #(.N_SPR(4), .CHK_LAT(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .spr_en(spr_en),
    .spr_xpos(spr_xpos), .spr_ypos(spr_ypos), .spr_W(spr_W), .spr_H(spr_H),
    .spr_dir(spr_dir), .spr_bcing(spr_bcing),
    .chk_xpos(chk_xpos0), .chk_ypos(chk_ypos0), .chk_W(chk_W0), .chk_H(chk_H0),
    .chk_dir(chk_dir0), .chk_bcing(chk_bcing0), .chk_bnce(chk_bnce0),
    .bnce_out(bnce_out0), .coll_out(coll_out0), .busy(busy0), .done(done0),
    .overrun(overrun0));

  bounce_check_scheduler #(.N_SPR(4), .CHK_LAT(2)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .spr_en(spr_en),
    .spr_xpos(spr_xpos), .spr_ypos(spr_ypos), .spr_W(spr_W), .spr_H(spr_H),
    .spr_dir(spr_dir), .spr_bcing(spr_bcing),
    .chk_xpos(chk_xpos2), .chk_ypos(chk_ypos2), .chk_W(chk_W2), .chk_H(chk_H2),
    .chk_dir(chk_dir2), .chk_bcing(chk_bcing2), .chk_bnce(chk_bnce2),
    .bnce_out(bnce_out2), .coll_out(coll_out2), .busy(busy2), .done(done2),
    .overrun(overrun2));

  // Current sprite field values driven onto the packed input buses
  logic [19:0] cx [4];
  logic [19:0] cy [4];
  logic [9:0]  cw [4];
  logic [9:0]  ch [4];
  logic [3:0]  cd [4];
  logic [3:0]  cb [4];
  logic [15:0] exp_bnce;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic apply_fields();
    for (int i = 0; i < 4; i++) begin
      spr_xpos[20*i +: 20] = cx[i];
      spr_ypos[20*i +: 20] = cy[i];
      spr_W[10*i +: 10]    = cw[i];
      spr_H[10*i +: 10]    = ch[i];
      spr_dir[4*i +: 4]    = cd[i];
      spr_bcing[4*i +: 4]  = cb[i];
    end
  endtask

  task automatic random_fields();
    for (int i = 0; i < 4; i++) begin
      cx[i] = 20'($urandom);
      cy[i] = 20'($urandom);
      cw[i] = 10'($urandom);
      ch[i] = 10'($urandom);
      cd[i] = 4'($urandom);
      cb[i] = 4'($urandom);
    end
    apply_fields();
  endtask

  function automatic logic [3:0] coll_of(input logic [15:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = |b[4*i +: 4];
    return r;
  endfunction

  // Runs one frame from the current negedge. Expectations come from the
  // frame-level rules: enabled sprites visit the checker in ascending order,
  // each for lat+1 cycles; done comes at 1 + E*(lat+1); results appear in the
  // cycle after done.
  // fs2 > 0 re-asserts frame_start in that cycle, which must fall while both
  // instances are busy.
  task automatic do_frame(input string tag, input logic [3:0] en, input int fs2,
                          input bit scramble, output int seen0, output int seen2);
    int          lat [2];
    int          exp_done [2];
    int          q [$];
    int          k, last;
    logic [19:0] sx [4];
    logic [19:0] sy [4];
    logic [9:0]  sw [4];
    logic [9:0]  sh [4];
    logic [3:0]  sd [4];
    logic [3:0]  sb [4];
    logic [15:0] new_b, want_b;
    logic [67:0] ec;
    lat[0] = 0;
    lat[1] = 2;
    spr_en = en;
    new_b  = '0;
    q      = {};
    for (int i = 0; i < 4; i++) begin
      sx[i] = cx[i]; sy[i] = cy[i]; sw[i] = cw[i];
      sh[i] = ch[i]; sd[i] = cd[i]; sb[i] = cb[i];
      if (en[i]) begin
        q.push_back(i);
        new_b[4*i +: 4] = chk_fn(sx[i], sy[i], sw[i], sh[i], sd[i], sb[i]);
      end
    end
    for (int d = 0; d < 2; d++) exp_done[d] = 1 + q.size() * (lat[d] + 1);
    last  = exp_done[1] + 1;
    seen0 = -1;
    seen2 = -1;
    frame_start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge Clk);
      if (done0 && seen0 < 0) seen0 = c;
      if (done2 && seen2 < 0) seen2 = c;
      for (int d = 0; d < 2; d++) begin
        ec = '0;
        if (c <= q.size() * (lat[d] + 1)) begin
          k  = q[(c - 1) / (lat[d] + 1)];
          ec = {sx[k], sy[k], sw[k], sh[k], sd[k], sb[k]};
        end
        if (c <= exp_done[d] + 1) begin
          want_b = (c <= exp_done[d]) ? exp_bnce : new_b;
          check($sformatf("%s_chk d%0d c%0d", tag, d, c), chk_v[d], ec);
          check($sformatf("%s_done d%0d c%0d", tag, d, c), done_v[d], c == exp_done[d]);
          check($sformatf("%s_busy d%0d c%0d", tag, d, c), busy_v[d], c <= exp_done[d]);
          check($sformatf("%s_bnce d%0d c%0d", tag, d, c), bnce_v[d], want_b);
          check($sformatf("%s_coll d%0d c%0d", tag, d, c), coll_v[d], coll_of(want_b));
        end
        check($sformatf("%s_ovr d%0d c%0d", tag, d, c), ovr_v[d], (fs2 >= 1) && (c == fs2 + 1));
      end
      frame_start = (c == fs2);
      if (scramble) begin
        random_fields();
        spr_en = 4'($urandom);
      end
    end
    frame_start = 1'b0;
    exp_bnce    = new_b;
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [15:0] xlo;   // x low nibble of each sprite; all other fields are 0
    logic [15:0] bnce;
    logic [3:0]  coll;
    int          done0;
    int          done2;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int s0, s2, e, fs2;
    logic [3:0] en_r;

    tbl[0] = '{en: 4'hF, xlo: 16'h0010, bnce: 16'h0010, coll: 4'b0010, done0: 5, done2: 13};
    tbl[1] = '{en: 4'hA, xlo: 16'h4321, bnce: 16'h4020, coll: 4'b1010, done0: 3, done2: 7};
    tbl[2] = '{en: 4'h0, xlo: 16'hFFFF, bnce: 16'h0000, coll: 4'b0000, done0: 1, done2: 1};
    tbl[3] = '{en: 4'h5, xlo: 16'h0F0F, bnce: 16'h0F0F, coll: 4'b0101, done0: 3, done2: 7};
    tbl[4] = '{en: 4'h8, xlo: 16'h9000, bnce: 16'h9000, coll: 4'b1000, done0: 2, done2: 4};
    tbl[5] = '{en: 4'hF, xlo: 16'h0000, bnce: 16'h0000, coll: 4'b0000, done0: 5, done2: 13};
    tbl[6] = '{en: 4'h7, xlo: 16'h8421, bnce: 16'h0421, coll: 4'b0111, done0: 4, done2: 10};

    Reset_n     = 1'b0;
    frame_start = 1'b0;
    spr_en      = '0;
    for (int i = 0; i < 4; i++) begin
      cx[i] = '0; cy[i] = '0; cw[i] = '0; ch[i] = '0; cd[i] = '0; cb[i] = '0;
    end
    apply_fields();
    exp_bnce = '0;
    repeat (3) @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_chk d%0d", d), chk_v[d], 68'd0);
      check($sformatf("rst_bnce d%0d", d), bnce_v[d], 16'd0);
      check($sformatf("rst_ctl d%0d", d), {busy_v[d], done_v[d], ovr_v[d], coll_v[d]}, 7'd0);
    end
    Reset_n = 1'b1;
    @(negedge Clk);

    // Table of hand-derived frames
    foreach (tbl[t]) begin
      for (int i = 0; i < 4; i++) begin
        cx[i] = 20'(tbl[t].xlo[4*i +: 4]);
        cy[i] = '0; cw[i] = '0; ch[i] = '0; cd[i] = '0; cb[i] = '0;
      end
      apply_fields();
      do_frame($sformatf("tbl%0d", t), tbl[t].en, 0, 1'b0, s0, s2);
      check($sformatf("tbl%0d_done_cyc d0", t), s0, tbl[t].done0);
      check($sformatf("tbl%0d_done_cyc d2", t), s2, tbl[t].done2);
      check($sformatf("tbl%0d_bnce d0", t), bnce_out0, tbl[t].bnce);
      check($sformatf("tbl%0d_bnce d2", t), bnce_out2, tbl[t].bnce);
      check($sformatf("tbl%0d_coll d0", t), coll_out0, tbl[t].coll);
      check($sformatf("tbl%0d_coll d2", t), coll_out2, tbl[t].coll);
    end

    // Reset asserted while the CHK_LAT=2 instance is on sprite 2
    for (int i = 0; i < 4; i++) cx[i] = 20'(i + 1);
    apply_fields();
    spr_en      = 4'hF;
    frame_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      frame_start = 1'b0;
    end
    check("pre_rst_bnce d0", bnce_out0, 16'h4321);
    Reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst_chk d%0d", d), chk_v[d], 68'd0);
      check($sformatf("midrst_bnce d%0d", d), bnce_v[d], 16'd0);
      check($sformatf("midrst_ctl d%0d", d), {busy_v[d], done_v[d], ovr_v[d], coll_v[d]}, 7'd0);
    end
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("postrst_idle d%0d", d), {busy_v[d], done_v[d]}, 2'd0);
      check($sformatf("postrst_bnce d%0d", d), bnce_v[d], 16'd0);
      check($sformatf("postrst_chk d%0d", d), chk_v[d], 68'd0);
    end
    exp_bnce = '0;
    do_frame("after_rst", 4'hF, 0, 1'b0, s0, s2);

    // Overrun during SCAN, then during the CHK_LAT=0 instance's COMMIT
    random_fields();
    do_frame("ovr_scan", 4'hF, 2, 1'b0, s0, s2);
    random_fields();
    do_frame("ovr_commit", 4'hF, 5, 1'b0, s0, s2);

    // Inputs changing during the scan must not leak through
    random_fields();
    do_frame("snap", 4'hB, 0, 1'b1, s0, s2);

    // Randomized frames, back to back, inputs scrambled during each scan
    for (int r = 0; r < 25; r++) begin
      random_fields();
      en_r = 4'($urandom);
      e    = $countones(en_r);
      fs2  = 0;
      if (e > 0 && $urandom_range(0, 2) == 0) fs2 = $urandom_range(1, 1 + e);
      do_frame($sformatf("rnd%0d", r), en_r, fs2, 1'b1, s0, s2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
